// File: rtl/mem_pkg.sv
// Shared memory-hierarchy types: L1<->L2 and L2<->memory bus structs,
// the L2 controller state encoding and the L2 line entry layout.
package mem_pkg;

    localparam int BLOCKSIZE       = 128;
    localparam int BYTE_ADDR_BITS  = 4;
    localparam int ADDR_W          = 32;
    localparam int L2_SETS_DEFAULT = 64;
    // Widest tag any legal set count can need (a single-set cache).
    localparam int TAG_W_MAX       = ADDR_W - BYTE_ADDR_BITS;

    typedef struct packed {
        logic                 Valid;
        logic                 Wen;
        logic                 Src;
        logic [ADDR_W-1:0]    Addr;
        logic [BLOCKSIZE-1:0] WriteD;
    } L1ToL2_t;

    typedef struct packed {
        logic                 Ready;
        logic                 Dst;
        logic [BLOCKSIZE-1:0] ReadD;
    } L2ToL1_t;

    typedef struct packed {
        logic                 Valid;
        logic                 Wen;
        logic [ADDR_W-1:0]    Addr;
        logic [BLOCKSIZE-1:0] WriteD;
    } L2ToMem_t;

    typedef struct packed {
        logic                 Ready;
        logic [BLOCKSIZE-1:0] ReadD;
    } MemToL2_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_READ,
        MEM_WRITE,
        RESPOND
    } l2_state_e;

    // Tags are stored zero-extended to the widest possible tag so the entry
    // layout does not depend on the set count.
    typedef struct packed {
        logic                 Valid;
        logic [TAG_W_MAX-1:0] Tag;
        logic [BLOCKSIZE-1:0] Data;
    } l2_entry_t;

    // Clear the byte-offset bits so memory only ever sees block addresses.
    function automatic logic [ADDR_W-1:0] blk_addr(input logic [ADDR_W-1:0] a);
        return a & ~(ADDR_W'((1 << BYTE_ADDR_BITS) - 1));
    endfunction

endpackage

// File: rtl/l2_shared_cache_line_store.sv
// L2 line storage: tag+data held in an inferred RAM with a registered read
// port, valid bits kept in flops so that reset invalidates every line in a
// single cycle.
module l2_shared_cache_line_store
    import mem_pkg::*;
#(
    parameter int SETS  = L2_SETS_DEFAULT,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rd_en_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output l2_entry_t        rd_entry_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  l2_entry_t        wr_entry_i
);

    localparam int WORD_W = TAG_W_MAX + BLOCKSIZE;

    logic [WORD_W-1:0] ram [SETS];
    logic [WORD_W-1:0] rd_word_q;
    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   valid_d;
    logic [SETS-1:0]   wr_sel;
    logic              rd_valid_q;
    logic              rd_valid_d;

    // One-hot decode of the write index.
    for (genvar gi = 0; gi < SETS; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wr_en_i && (wr_idx_i == IDX_W'(gi));
    end

    // Valid-array update and the valid bit for the registered read.
    always_comb begin
        valid_d    = (valid_q & ~wr_sel) | (wr_sel & {SETS{wr_entry_i.Valid}});
        rd_valid_d = rd_valid_q;
        if (rd_en_i) begin
            rd_valid_d = valid_q[rd_idx_i];
        end
    end

    // Valid flops: cleared together on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Tag/data RAM: write port plus registered read port. A write followed
    // by a read of the same set on the next cycle sees the new contents.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            ram[wr_idx_i] <= {wr_entry_i.Tag, wr_entry_i.Data};
        end
        if (rd_en_i) begin
            rd_word_q <= ram[rd_idx_i];
        end
    end

    assign rd_entry_o.Valid = rd_valid_q;
    assign rd_entry_o.Tag   = rd_word_q[WORD_W-1:BLOCKSIZE];
    assign rd_entry_o.Data  = rd_word_q[BLOCKSIZE-1:0];

endmodule

// File: rtl/l2_shared_cache.sv
// Shared L2: direct-mapped, write-through, write-allocate responder for the
// L1 instruction/data pair. One request in flight; responses are steered back
// by echoing the requester's Src on Dst.
module l2_shared_cache
    import mem_pkg::*;
#(
    parameter int L2_SETS     = L2_SETS_DEFAULT,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  L1ToL2_t  req_i,
    output L2ToL1_t  resp_o,
    output L2ToMem_t mem_o,
    input  MemToL2_t mem_i,
    output logic     err_o
);

    localparam int IDX_W   = $clog2(L2_SETS);
    localparam int TAG_LSB = BYTE_ADDR_BITS + IDX_W;
    localparam int CNT_W   = 32;

    l2_state_e            state_q, state_d;
    logic                 wen_q, wen_d;
    logic                 src_q, src_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [BLOCKSIZE-1:0] wdata_q, wdata_d;
    logic [BLOCKSIZE-1:0] resp_data_q, resp_data_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;

    logic                 store_rd_en;
    logic [IDX_W-1:0]     store_rd_idx;
    l2_entry_t            store_rd_entry;
    logic                 store_wr_en;
    l2_entry_t            store_wr_entry;
    logic                 hit;

    function automatic logic [TAG_W_MAX-1:0] tag_of(input logic [ADDR_W-1:0] a);
        return TAG_W_MAX'(a >> TAG_LSB);
    endfunction

    // The line is read while the request is sampled in IDLE so the
    // registered result is ready during LOOKUP.
    assign store_rd_en  = (state_q == IDLE) && req_i.Valid;
    assign store_rd_idx = req_i.Addr[BYTE_ADDR_BITS +: IDX_W];

    assign hit = store_rd_entry.Valid && (store_rd_entry.Tag == tag_of(addr_q));

    l2_shared_cache_line_store #(
        .SETS  (L2_SETS),
        .IDX_W (IDX_W)
    ) u_line_store (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_en_i    (store_rd_en),
        .rd_idx_i   (store_rd_idx),
        .rd_entry_o (store_rd_entry),
        .wr_en_i    (store_wr_en),
        .wr_idx_i   (addr_q[BYTE_ADDR_BITS +: IDX_W]),
        .wr_entry_i (store_wr_entry)
    );

    // Controller next-state, request latching, line writes and timeout.
    always_comb begin
        state_d              = state_q;
        wen_d                = wen_q;
        src_d                = src_q;
        addr_d               = addr_q;
        wdata_d              = wdata_q;
        resp_data_d          = resp_data_q;
        err_d                = err_q;
        wait_cnt_d           = '0;
        store_wr_en          = 1'b0;
        store_wr_entry.Valid = 1'b1;
        store_wr_entry.Tag   = tag_of(addr_q);
        store_wr_entry.Data  = wdata_q;

        unique case (state_q)
            IDLE: begin
                if (req_i.Valid) begin
                    wen_d   = req_i.Wen;
                    src_d   = req_i.Src;
                    addr_d  = req_i.Addr;
                    wdata_d = req_i.WriteD;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (wen_q) begin
                    // Write-allocate: the line takes the new block whether
                    // or not it hit; a conflicting tag is simply replaced.
                    store_wr_en = 1'b1;
                    state_d     = MEM_WRITE;
                end else if (hit) begin
                    resp_data_d = store_rd_entry.Data;
                    state_d     = RESPOND;
                end else begin
                    state_d = MEM_READ;
                end
            end
            MEM_READ: begin
                if (mem_i.Ready) begin
                    store_wr_en         = 1'b1;
                    store_wr_entry.Data = mem_i.ReadD;
                    resp_data_d         = mem_i.ReadD;
                    state_d             = RESPOND;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            MEM_WRITE: begin
                if (mem_i.Ready) begin
                    resp_data_d = wdata_q;
                    state_d     = RESPOND;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Debug-only watchdog on memory; the FSM keeps waiting regardless.
        if ((MEM_TIMEOUT > 0) && (wait_cnt_d >= CNT_W'(MEM_TIMEOUT))) begin
            err_d = 1'b1;
        end
    end

    // State and latch registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            wen_q       <= 1'b0;
            src_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wen_q       <= wen_d;
            src_q       <= src_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_data_q <= resp_data_d;
            err_q       <= err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign resp_o.Ready  = (state_q == RESPOND);
    assign resp_o.Dst    = src_q;
    assign resp_o.ReadD  = resp_data_q;

    assign mem_o.Valid   = (state_q == MEM_READ) || (state_q == MEM_WRITE);
    assign mem_o.Wen     = (state_q == MEM_WRITE);
    assign mem_o.Addr    = blk_addr(addr_q);
    assign mem_o.WriteD  = wdata_q;

    assign err_o = err_q;

endmodule

// File: tb/tb_l2_shared_cache.sv
// Directed bench for l2_shared_cache with a behavioural main memory and a
// response scoreboard.
module tb_l2_shared_cache;
    import mem_pkg::*;

    typedef struct packed {
        logic                 dst;
        logic [BLOCKSIZE-1:0] data;
    } exp_t;

    logic     clk = 1'b0;
    logic     rst;
    L1ToL2_t  req;
    L2ToL1_t  resp;
    L2ToMem_t memo;
    MemToL2_t memi;
    logic     err;

    int n_checks = 0;
    int n_errs   = 0;

    exp_t sb[$];
    logic [BLOCKSIZE-1:0] mem_arr [logic [31:0]];
    int   mem_delay = 3;
    bit   mem_en    = 1'b1;
    int   mcnt      = 0;
    int   mem_rd_txn = 0;
    int   mem_wr_txn = 0;
    logic [31:0]          last_wr_addr = '0;
    logic [BLOCKSIZE-1:0] last_wr_data = '0;
    int   cyc = 0, last_mrdy = 0, last_resp = 0, ready_cnt = 0, mvalid_cnt = 0;

    always #5 clk = ~clk;

    l2_shared_cache #(
        .L2_SETS     (64),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .req_i  (req),
        .resp_o (resp),
        .mem_o  (memo),
        .mem_i  (memi),
        .err_o  (err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return {4{a ^ 32'h5A5A_0000}};
    endfunction

    // Main memory: answers each request after mem_delay cycles with a
    // one-cycle Ready pulse.
    initial memi = '0;
    always begin
        @(posedge clk);
        #1;
        if (memi.Ready) begin
            memi.Ready = 1'b0;
            mcnt = 0;
        end else if (memo.Valid && mem_en && !rst) begin
            mcnt++;
            if (mcnt >= mem_delay) begin
                mcnt = 0;
                memi.Ready = 1'b1;
                if (memo.Wen) begin
                    mem_arr[memo.Addr] = memo.WriteD;
                    last_wr_addr = memo.Addr;
                    last_wr_data = memo.WriteD;
                    mem_wr_txn++;
                end else begin
                    memi.ReadD = mem_read(memo.Addr);
                    mem_rd_txn++;
                end
            end
        end else begin
            mcnt = 0;
        end
    end

    // Response monitor: every Ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (memi.Ready) last_mrdy = cyc;
        if (memo.Valid) mvalid_cnt++;
        if (resp.Ready) begin
            ready_cnt++;
            last_resp = cyc;
            chk("resp_expected", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("resp_dst", 128'(resp.Dst), 128'(e.dst));
                chk("resp_data", resp.ReadD, e.data);
            end
        end
    end

    // Present a request at posedge+1 and hold it until the matching Ready;
    // returns at posedge+1 of the following cycle with the request still held.
    task automatic issue(input logic src, input logic wen, input logic [31:0] addr,
                         input logic [127:0] wd, input logic [127:0] expd, output int lat);
        exp_t e;
        e.dst  = src;
        e.data = expd;
        sb.push_back(e);
        req.Valid  = 1'b1;
        req.Wen    = wen;
        req.Src    = src;
        req.Addr   = addr;
        req.WriteD = wd;
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (resp.Ready && resp.Dst == src) begin
                lat = n;
                break;
            end
        end
        chk("resp_within_bound", 128'(lat >= 0), 128'd1);
        $display("txn src=%0d wen=%0d addr=%08h lat=%0d data=%0h", src, wen, addr, lat, resp.ReadD);
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic src, input logic wen, input logic [31:0] addr,
                          input logic [127:0] wd, input logic [127:0] expd, output int lat);
        issue(src, wen, addr, wd, expd, lat);
        req.Valid = 1'b0;
        req.Wen   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, m0, w0, v0, r0, wc;
        logic [127:0] d200;
        rst = 1'b1;
        req = '0;
        mem_arr[32'h100] = {16{8'hA5}};
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 128'(resp.Ready), 128'd0);
        chk("rst_dst", 128'(resp.Dst), 128'd0);
        chk("rst_readd", resp.ReadD, 128'd0);
        chk("rst_mem_valid", 128'(memo.Valid), 128'd0);
        chk("rst_mem_wen", 128'(memo.Wen), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        @(posedge clk);
        #1;

        // Cold read miss, then hit.
        m0 = mem_rd_txn;
        do_req(1'b1, 1'b0, 32'h100, '0, {16{8'hA5}}, lat);
        chk("cold_mem_reads", 128'(mem_rd_txn - m0), 128'd1);
        chk("miss_ready_after_mem", 128'(last_resp - last_mrdy), 128'd1);
        v0 = mvalid_cnt;
        do_req(1'b1, 1'b0, 32'h100, '0, {16{8'hA5}}, lat);
        chk("hit_latency", 128'(lat), 128'd2);
        chk("hit_no_mem_valid", 128'(mvalid_cnt - v0), 128'd0);

        // Write-through, then hit from the other L1.
        w0 = mem_wr_txn;
        do_req(1'b1, 1'b1, 32'h104, 128'h1234, 128'h1234, lat);
        chk("wr_mem_writes", 128'(mem_wr_txn - w0), 128'd1);
        chk("wr_mem_addr", 128'(last_wr_addr), 128'h100);
        chk("wr_mem_data", last_wr_data, 128'h1234);
        chk("wr_ready_after_mem", 128'(last_resp - last_mrdy), 128'd1);
        v0 = mvalid_cnt;
        do_req(1'b0, 1'b0, 32'h108, '0, 128'h1234, lat);
        chk("src0_hit_latency", 128'(lat), 128'd2);
        chk("src0_hit_no_mem", 128'(mvalid_cnt - v0), 128'd0);

        // Alias in the same set replaces the line.
        m0 = mem_rd_txn;
        do_req(1'b1, 1'b0, 32'h100 + 32'd1024, '0, mem_read(32'h500), lat);
        chk("alias_miss", 128'(mem_rd_txn - m0), 128'd1);
        do_req(1'b1, 1'b0, 32'h100, '0, 128'h1234, lat);
        chk("alias_reread_miss", 128'(mem_rd_txn - m0), 128'd2);

        // L1D: read miss immediately followed by a held write.
        r0 = ready_cnt;
        m0 = mem_rd_txn;
        d200 = mem_read(32'h200);
        issue(1'b1, 1'b0, 32'h200, '0, d200, lat);
        issue(1'b1, 1'b1, 32'h200, 128'hDEAD_BEEF, 128'hDEAD_BEEF, lat);
        req.Valid = 1'b0;
        req.Wen   = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("l1d_two_pulses", 128'(ready_cnt - r0), 128'd2);
        chk("l1d_one_read", 128'(mem_rd_txn - m0), 128'd1);
        chk("l1d_wr_addr", 128'(last_wr_addr), 128'h200);
        chk("l1d_wr_data", last_wr_data, 128'hDEAD_BEEF);

        // Reset while waiting on a memory read.
        mem_delay = 6;
        r0 = ready_cnt;
        req.Valid = 1'b1;
        req.Wen   = 1'b0;
        req.Src   = 1'b0;
        req.Addr  = 32'h300;
        wc = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (memo.Valid) begin
                wc = 1;
                break;
            end
        end
        chk("rst_mid_mem_valid_seen", 128'(wc), 128'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req.Valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_mem_valid_low", 128'(memo.Valid), 128'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("rst_mid_no_ready", 128'(ready_cnt - r0), 128'd0);
        mem_delay = 3;
        m0 = mem_rd_txn;
        do_req(1'b0, 1'b0, 32'h300, '0, mem_read(32'h300), lat);
        chk("post_rst_miss", 128'(mem_rd_txn - m0), 128'd1);
        do_req(1'b0, 1'b0, 32'h100, '0, 128'h1234, lat);
        chk("post_rst_all_invalid", 128'(mem_rd_txn - m0), 128'd2);

        // Memory never answers: sticky timeout flag, no response.
        mem_en = 1'b0;
        r0 = ready_cnt;
        req.Valid = 1'b1;
        req.Wen   = 1'b0;
        req.Src   = 1'b1;
        req.Addr  = 32'h400;
        wc = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (memo.Valid) begin
                wc++;
                if (wc == 7)  chk("timeout_err_early", 128'(err), 128'd0);
                if (wc == 9)  chk("timeout_err_set", 128'(err), 128'd1);
                if (wc == 20) begin
                    chk("timeout_err_sticky", 128'(err), 128'd1);
                    break;
                end
            end
        end
        chk("timeout_wait_cycles", 128'(wc), 128'd20);
        chk("timeout_no_ready", 128'(ready_cnt - r0), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req.Valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_en = 1'b1;
        @(negedge clk);
        chk("timeout_err_cleared", 128'(err), 128'd0);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
